// File: rtl/focus_window_stats_pkg.sv
// Shared types and helpers for the auto-focus window statistics block.
package focus_window_stats_pkg;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    RUN       = 1'b1
  } state_e;

  // Wide working width for the saturating helpers; callers use w <= 62.
  localparam int unsigned ARITH_W = 64;

  function automatic logic [ARITH_W-1:0] max_of(input int unsigned w);
    return (ARITH_W'(1) << w) - ARITH_W'(1);
  endfunction

  function automatic logic [ARITH_W-1:0] sat_add(input logic [ARITH_W-1:0] a,
                                                 input logic [ARITH_W-1:0] b,
                                                 input int unsigned        w);
    logic [ARITH_W-1:0] sum;
    sum = a + b;
    return (sum > max_of(w)) ? max_of(w) : sum;
  endfunction

  function automatic logic sat_hit(input logic [ARITH_W-1:0] a,
                                   input logic [ARITH_W-1:0] b,
                                   input int unsigned        w);
    return (a + b) > max_of(w);
  endfunction

endpackage

// File: rtl/focus_window_stats_grad_pipe.sv
// Two-stage pixel pipe: previous-pixel register, absolute horizontal gradient,
// and qualifier alignment into the accumulate stage.
module focus_window_stats_grad_pipe #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              de_i,
  input  logic              activ_c_i,
  input  logic [DATA_W-1:0] y_i,
  output logic [DATA_W-1:0] grad_o,
  output logic [DATA_W-1:0] y_o,
  output logic              q_o
);

  logic              q_c;
  logic [DATA_W-1:0] grad_c;
  logic [DATA_W-1:0] prev_y_q;
  logic              prev_q_q;
  logic [DATA_W-1:0] grad_q;
  logic [DATA_W-1:0] y_q;
  logic              q2_q;

  assign q_c = de_i & activ_c_i;

  // Gradient is only meaningful between two consecutive qualified pixels.
  always_comb begin
    grad_c = '0;
    if (q_c && prev_q_q) begin
      grad_c = (y_i > prev_y_q) ? (y_i - prev_y_q) : (prev_y_q - y_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_y_q <= '0;
      prev_q_q <= 1'b0;
      grad_q   <= '0;
      y_q      <= '0;
      q2_q     <= 1'b0;
    end else begin
      prev_y_q <= y_i;
      prev_q_q <= q_c;
      grad_q   <= grad_c;
      y_q      <= q_c ? y_i : '0;
      q2_q     <= q_c;
    end
  end

  assign grad_o = grad_q;
  assign y_o    = y_q;
  assign q_o    = q2_q;

endmodule

// File: rtl/focus_window_stats.sv
// Per-frame focus statistics inside the centre window, peak tracking across
// frames, and window-outline overlay onto the outgoing video.
module focus_window_stats
  import focus_window_stats_pkg::*;
#(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       SUM_W    = 32,
  parameter int unsigned       CNT_W    = 24,
  parameter logic [DATA_W-1:0] LINE_VAL = DATA_W'(8'hFF)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              VS,
  input  logic              DE,
  input  logic [DATA_W-1:0] Y_IN,
  input  logic              ACTIV_C,
  input  logic              LINE,
  input  logic              PEAK_CLR,
  output logic [DATA_W-1:0] Y_OUT,
  output logic              DE_OUT,
  output logic [SUM_W-1:0]  FOCUS_VAL,
  output logic [SUM_W-1:0]  LUMA_SUM,
  output logic [CNT_W-1:0]  PIX_CNT,
  output logic              OVERFLOW,
  output logic              STAT_VALID,
  output logic [SUM_W-1:0]  FOCUS_PEAK,
  output logic              NEW_PEAK
);

  logic [DATA_W-1:0] grad_w;
  logic [DATA_W-1:0] y_w;
  logic              q_w;

  focus_window_stats_grad_pipe #(.DATA_W(DATA_W)) u_grad_pipe (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .de_i      (DE),
    .activ_c_i (ACTIV_C),
    .y_i       (Y_IN),
    .grad_o    (grad_w),
    .y_o       (y_w),
    .q_o       (q_w)
  );

  state_e            state_q, state_d;
  logic              rvs_q;
  logic [SUM_W-1:0]  acc_f_q, acc_f_d, acc_l_q, acc_l_d;
  logic [CNT_W-1:0]  acc_n_q, acc_n_d;
  logic              ovf_q, ovf_d;
  logic [SUM_W-1:0]  focus_val_q, focus_val_d, luma_sum_q, luma_sum_d;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic              overflow_q, overflow_d;
  logic              stat_valid_q, stat_valid_d;
  logic [SUM_W-1:0]  peak_q, peak_d;
  logic              new_peak_q, new_peak_d;
  logic [DATA_W-1:0] y_out_q;
  logic              de_out_q;

  logic              vs_rise_c;
  logic              add_c;
  logic [SUM_W-1:0]  f_nx_c, l_nx_c;
  logic [CNT_W-1:0]  n_nx_c;
  logic              ovf_nx_c;

  // Accumulator next-values including this cycle's qualified pixel.
  always_comb begin
    vs_rise_c = VS & ~rvs_q;
    add_c     = (state_q == RUN) && q_w;
    f_nx_c    = acc_f_q;
    l_nx_c    = acc_l_q;
    n_nx_c    = acc_n_q;
    ovf_nx_c  = ovf_q;
    if (add_c) begin
      f_nx_c   = SUM_W'(sat_add(ARITH_W'(acc_f_q), ARITH_W'(grad_w), SUM_W));
      l_nx_c   = SUM_W'(sat_add(ARITH_W'(acc_l_q), ARITH_W'(y_w), SUM_W));
      n_nx_c   = CNT_W'(sat_add(ARITH_W'(acc_n_q), ARITH_W'(1), CNT_W));
      ovf_nx_c = ovf_q
               | sat_hit(ARITH_W'(acc_f_q), ARITH_W'(grad_w), SUM_W)
               | sat_hit(ARITH_W'(acc_l_q), ARITH_W'(y_w), SUM_W)
               | sat_hit(ARITH_W'(acc_n_q), ARITH_W'(1), CNT_W);
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_f_d      = acc_f_q;
    acc_l_d      = acc_l_q;
    acc_n_d      = acc_n_q;
    ovf_d        = ovf_q;
    focus_val_d  = focus_val_q;
    luma_sum_d   = luma_sum_q;
    pix_cnt_d    = pix_cnt_q;
    overflow_d   = overflow_q;
    stat_valid_d = 1'b0;
    new_peak_d   = 1'b0;
    peak_d       = PEAK_CLR ? '0 : peak_q;
    case (state_q)
      WAIT_SYNC: begin
        if (vs_rise_c) begin
          state_d = RUN;
          acc_f_d = '0;
          acc_l_d = '0;
          acc_n_d = '0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        acc_f_d = f_nx_c;
        acc_l_d = l_nx_c;
        acc_n_d = n_nx_c;
        ovf_d   = ovf_nx_c;
        if (vs_rise_c) begin
          focus_val_d  = f_nx_c;
          luma_sum_d   = l_nx_c;
          pix_cnt_d    = n_nx_c;
          overflow_d   = ovf_nx_c;
          stat_valid_d = 1'b1;
          acc_f_d      = '0;
          acc_l_d      = '0;
          acc_n_d      = '0;
          ovf_d        = 1'b0;
          // A coincident clear makes the comparison baseline zero.
          if (f_nx_c > peak_d) begin
            peak_d     = f_nx_c;
            new_peak_d = 1'b1;
          end
        end
      end
      default: state_d = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= WAIT_SYNC;
      rvs_q        <= 1'b0;
      acc_f_q      <= '0;
      acc_l_q      <= '0;
      acc_n_q      <= '0;
      ovf_q        <= 1'b0;
      focus_val_q  <= '0;
      luma_sum_q   <= '0;
      pix_cnt_q    <= '0;
      overflow_q   <= 1'b0;
      stat_valid_q <= 1'b0;
      peak_q       <= '0;
      new_peak_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rvs_q        <= VS;
      acc_f_q      <= acc_f_d;
      acc_l_q      <= acc_l_d;
      acc_n_q      <= acc_n_d;
      ovf_q        <= ovf_d;
      focus_val_q  <= focus_val_d;
      luma_sum_q   <= luma_sum_d;
      pix_cnt_q    <= pix_cnt_d;
      overflow_q   <= overflow_d;
      stat_valid_q <= stat_valid_d;
      peak_q       <= peak_d;
      new_peak_q   <= new_peak_d;
    end
  end

  // Outline overlay applies regardless of DE.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      y_out_q  <= '0;
      de_out_q <= 1'b0;
    end else begin
      y_out_q  <= LINE ? LINE_VAL : Y_IN;
      de_out_q <= DE;
    end
  end

  assign Y_OUT      = y_out_q;
  assign DE_OUT     = de_out_q;
  assign FOCUS_VAL  = focus_val_q;
  assign LUMA_SUM   = luma_sum_q;
  assign PIX_CNT    = pix_cnt_q;
  assign OVERFLOW   = overflow_q;
  assign STAT_VALID = stat_valid_q;
  assign FOCUS_PEAK = peak_q;
  assign NEW_PEAK   = new_peak_q;

endmodule

// File: doc/focus_window_stats.md
Name: focus_window_stats

Overview:
- Downstream consumer of the pixel/line counter stage; sits between the counter and the auto-focus control logic.
- Takes per-pixel luma plus the counter's ACTIV_C (centre-window) and LINE (window outline) qualifiers.
- Accumulates a per-frame sharpness metric (sum of absolute horizontal gradients), a luma sum and a pixel count inside the window.
- Tracks the peak sharpness across frames and overlays the window outline onto the outgoing video.

Parameters:
DATA_W, 8, luma width
SUM_W, 32, width of FOCUS_VAL, LUMA_SUM, FOCUS_PEAK accumulators
CNT_W, 24, width of PIX_CNT
LINE_VAL, 8'hFF, luma driven on outline pixels (DATA_W bits)

Ports:
CLK  in  1  pixel clock
RESET_N  in  1  asynchronous active-low reset
VS  in  1  vertical sync, frame boundary on rising edge
DE  in  1  pixel data enable
Y_IN  in  DATA_W  pixel luma, aligned with ACTIV_C/LINE
ACTIV_C  in  1  pixel lies inside centre window
LINE  in  1  pixel lies on window outline
PEAK_CLR  in  1  one-cycle request to clear FOCUS_PEAK
Y_OUT  out  DATA_W  overlaid luma
DE_OUT  out  1  DE delayed to match Y_OUT
FOCUS_VAL  out  SUM_W  last complete frame gradient sum
LUMA_SUM  out  SUM_W  last complete frame luma sum
PIX_CNT  out  CNT_W  last complete frame window pixel count
OVERFLOW  out  1  last frame saturated any accumulator
STAT_VALID  out  1  one-cycle pulse when stats update
FOCUS_PEAK  out  SUM_W  max FOCUS_VAL since last clear
NEW_PEAK  out  1  one-cycle pulse, coincident with STAT_VALID, when the peak was raised

Behaviour:
- Reset: all outputs 0; internal accumulators 0; state WAIT_SYNC.
- Input qualification:
  - q = DE & ACTIV_C.
  - rVS is the registered VS; vs_rise = VS & ~rVS.
- Gradient stage 1:
  - Register prev_y <= Y_IN and prev_q <= q every cycle.
  - grad = |Y_IN - prev_y| when q & prev_q, else 0.
  - The first window pixel of each row, and any pixel after a DE gap, contributes 0 gradient.
- Stage 2:
  - Register grad and Y_IN (when q) into the accumulate stage.
  - Accumulators update one cycle after the pixel.
- Accumulate (state RUN only):
  - acc_f += grad; acc_l += Y (q pixels only); acc_n += 1 per q pixel.
  - Each accumulator saturates at its all-ones value; saturation sets sticky ovf.
- State machine:
  - WAIT_SYNC: no accumulation, pipeline still runs. On vs_rise: clear accumulators, go to RUN, no STAT_VALID (partial frame discarded).
  - RUN, on vs_rise:
    - FOCUS_VAL/LUMA_SUM/PIX_CNT/OVERFLOW <= accumulator next-values, including any add occurring that same cycle.
    - Accumulators and ovf reset to 0; STAT_VALID = 1 for one cycle; stay in RUN.
- Output hold: stats outputs are held stable between STAT_VALID pulses.
- Empty window: PIX_CNT=0 frame still pulses STAT_VALID with zero values; peak not updated.
- Peak tracking, evaluated on the STAT_VALID cycle:
  - If frame value > FOCUS_PEAK: FOCUS_PEAK <= value and NEW_PEAK pulses.
  - PEAK_CLR alone: FOCUS_PEAK <= 0 next cycle.
  - PEAK_CLR coincident with frame end: compare against 0, i.e. FOCUS_PEAK <= value and NEW_PEAK = (value != 0).
- Overlay, 1-cycle latency:
  - Y_OUT <= LINE ? LINE_VAL : Y_IN; DE_OUT <= DE.
  - LINE takes effect irrespective of DE.
- Reset mid-frame: async clear, back to WAIT_SYNC; the next frame boundary emits nothing, and the following one emits a full frame.
- Arithmetic: gradient computed as an unsigned difference of DATA_W operands (larger minus smaller), zero-extended into SUM_W.

Decomposition:
- Shared package: state enum {WAIT_SYNC, RUN}, and a saturating-add function parameterised by width.
- One natural sub-module: grad_pipe (stages 1–2: prev pixel register, abs-diff, qualifier alignment).
- Accumulators, FSM, peak tracker and overlay stay in the top.

Test Plan:
- After one dummy frame, a 4x2 window with rows Y=0,10,0,10 (DE, ACTIV_C high 4 consecutive cycles) -> on next VS rise: STAT_VALID=1, FOCUS_VAL=60, LUMA_SUM=40, PIX_CNT=8, OVERFLOW=0.
- Same window, DE low for one cycle between pixels 2 and 3 of each row -> FOCUS_VAL=40 (gap breaks gradient), PIX_CNT=8.
- SUM_W=8, two consecutive pixels 0,255,0 -> FOCUS_VAL=255 (saturated), OVERFLOW=1; following clean frame -> OVERFLOW=0.
- Frame sums 60, 30, 90 -> FOCUS_PEAK 60, 60, 90; NEW_PEAK on frames 1 and 3 only. PEAK_CLR on the frame-3 STAT_VALID cycle -> FOCUS_PEAK=90, NEW_PEAK=1.
- Assert RESET_N low mid-window, release, then VS rise -> no STAT_VALID, outputs 0; after one full frame -> correct stats.
- LINE=1 with Y_IN=8'h20 -> Y_OUT=8'hFF one cycle later; LINE=0 -> Y_OUT=Y_IN delayed 1; DE_OUT tracks DE delayed 1.
